switch_mcu_regfile: RTL and testbench

- Architectural register file (x0..x31, 32 bits each) for the switch core; it is the receiving end of the write ports driven by the ALU units (out_waddr/out_wen/out_wdata).
- Merges NUM_WPORTS ALU write ports with fixed priority and serves two registered read ports to the decoder.
- Detects and latches write collisions for debug.

---
 rtl/switch_mcu_regfile_pkg.sv | 18 +
 rtl/switch_mcu_regfile_wmerge.sv | 34 +++
 rtl/switch_mcu_regfile.sv | 111 +++++++++++
 tb/tb_switch_mcu_regfile.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_mcu_regfile_pkg.sv
// Shared constants and packed-port slicing helpers for the switch MCU register file.
package switch_mcu_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;
    localparam int XLEN_DEF   = 32;

    // Bit offset of write-port k inside the packed address bus.
    function automatic int waddr_lo(input int k);
        return k * REG_ADDR_W;
    endfunction

    // Bit offset of write-port k inside the packed data bus.
    function automatic int wdata_lo(input int k, input int xlen);
        return k * xlen;
    endfunction

endpackage

// File: rtl/switch_mcu_regfile_wmerge.sv
// Combinational fixed-priority merge of the ALU write ports into per-register
// write strobes and data, plus a per-register collision vector.
module switch_mcu_regfile_wmerge
    import switch_mcu_regfile_pkg::*;
#(
    parameter int NUM_WPORTS = 4,
    parameter int XLEN       = XLEN_DEF
) (
    input  logic [REG_ADDR_W*NUM_WPORTS-1:0] waddr,
    input  logic [NUM_WPORTS-1:0]            wen,
    input  logic [XLEN*NUM_WPORTS-1:0]       wdata,
    output logic [REG_NUM-1:0]               reg_we,
    output logic [REG_NUM-1:0][XLEN-1:0]     reg_wdata,
    output logic [REG_NUM-1:0]               coll_vec
);

    always_comb begin
        reg_we    = '0;
        reg_wdata = '0;
        coll_vec  = '0;
        // x0 is skipped entirely, so it is never written and never collides.
        // Ports are scanned high to low so the lowest-index hit is the one that sticks.
        for (int a = 1; a < REG_NUM; a++) begin
            for (int k = NUM_WPORTS - 1; k >= 0; k--) begin
                if (wen[k] && (waddr[waddr_lo(k) +: REG_ADDR_W] == REG_ADDR_W'(a))) begin
                    coll_vec[a]  = coll_vec[a] | reg_we[a];
                    reg_we[a]    = 1'b1;
                    reg_wdata[a] = wdata[wdata_lo(k, XLEN) +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/switch_mcu_regfile.sv
// Architectural register file: merged ALU write ports, two registered read
// ports with write-first bypass, and a sticky write-collision latch.
module switch_mcu_regfile
    import switch_mcu_regfile_pkg::*;
#(
    parameter int NUM_WPORTS = 4,
    parameter int XLEN       = XLEN_DEF
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic [REG_ADDR_W*NUM_WPORTS-1:0] in_waddr,
    input  logic [NUM_WPORTS-1:0]            in_wen,
    input  logic [XLEN*NUM_WPORTS-1:0]       in_wdata,
    input  logic [REG_ADDR_W-1:0]            in_raddr1,
    input  logic [REG_ADDR_W-1:0]            in_raddr2,
    input  logic                             in_ren,
    output logic [XLEN-1:0]                  out_rdata1,
    output logic [XLEN-1:0]                  out_rdata2,
    output logic                             out_collision,
    output logic [REG_ADDR_W-1:0]            out_coll_addr,
    input  logic                             in_clr_err
);

    logic [REG_NUM-1:0]           reg_we;
    logic [REG_NUM-1:0][XLEN-1:0] reg_wdata;
    logic [REG_NUM-1:0]           coll_vec;

    logic [REG_NUM-1:0][XLEN-1:0] regs_q, regs_d;
    logic [XLEN-1:0]              rdata1_q, rdata1_d;
    logic [XLEN-1:0]              rdata2_q, rdata2_d;
    logic                         coll_q, coll_d;
    logic [REG_ADDR_W-1:0]        coll_addr_q, coll_addr_d;
    logic [REG_ADDR_W-1:0]        coll_low;

    switch_mcu_regfile_wmerge #(
        .NUM_WPORTS (NUM_WPORTS),
        .XLEN       (XLEN)
    ) u_wmerge (
        .waddr     (in_waddr),
        .wen       (in_wen),
        .wdata     (in_wdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .coll_vec  (coll_vec)
    );

    always_comb begin
        regs_d = regs_q;
        for (int a = 1; a < REG_NUM; a++) begin
            if (reg_we[a]) begin
                regs_d[a] = reg_wdata[a];
            end
        end
    end

    // Reading regs_d gives write-first bypass; entry 0 is never written so x0 reads 0.
    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (in_ren) begin
            rdata1_d = regs_d[in_raddr1];
            rdata2_d = regs_d[in_raddr2];
        end
    end

    always_comb begin
        coll_low = '0;
        for (int a = REG_NUM - 1; a >= 1; a--) begin
            if (coll_vec[a]) begin
                coll_low = REG_ADDR_W'(a);
            end
        end
    end

    // A fresh collision beats a same-cycle clear; otherwise the first address is kept.
    always_comb begin
        coll_d      = coll_q;
        coll_addr_d = coll_addr_q;
        if (|coll_vec) begin
            coll_d = 1'b1;
            if (!coll_q || in_clr_err) begin
                coll_addr_d = coll_low;
            end
        end else if (in_clr_err) begin
            coll_d      = 1'b0;
            coll_addr_d = '0;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            regs_q      <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            coll_q      <= 1'b0;
            coll_addr_q <= '0;
        end else begin
            regs_q      <= regs_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            coll_q      <= coll_d;
            coll_addr_q <= coll_addr_d;
        end
    end

    assign out_rdata1    = rdata1_q;
    assign out_rdata2    = rdata2_q;
    assign out_collision = coll_q;
    assign out_coll_addr = coll_addr_q;

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Self-checking bench for switch_mcu_regfile: directed steps plus random traffic
// compared against a behavioural register-file model.
module tb_switch_mcu_regfile;

    localparam int NW = 4;
    localparam int XL = 32;

    logic            in_clk;
    logic            in_rst;
    logic [5*NW-1:0] in_waddr;
    logic [NW-1:0]   in_wen;
    logic [XL*NW-1:0] in_wdata;
    logic [4:0]      in_raddr1;
    logic [4:0]      in_raddr2;
    logic            in_ren;
    logic [XL-1:0]   out_rdata1;
    logic [XL-1:0]   out_rdata2;
    logic            out_collision;
    logic [4:0]      out_coll_addr;
    logic            in_clr_err;

    int total = 0;
    int bad   = 0;

    logic [XL-1:0] m_regs [32];
    logic [XL-1:0] m_r1, m_r2;
    logic          m_coll;
    logic [4:0]    m_caddr;

    switch_mcu_regfile #(.NUM_WPORTS(NW), .XLEN(XL)) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_waddr      (in_waddr),
        .in_wen        (in_wen),
        .in_wdata      (in_wdata),
        .in_raddr1     (in_raddr1),
        .in_raddr2     (in_raddr2),
        .in_ren        (in_ren),
        .out_rdata1    (out_rdata1),
        .out_rdata2    (out_rdata2),
        .out_collision (out_collision),
        .out_coll_addr (out_coll_addr),
        .in_clr_err    (in_clr_err)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_r1 = '0; m_r2 = '0; m_coll = 1'b0; m_caddr = '0;
    endtask

    task automatic idle();
        in_wen = '0; in_waddr = '0; in_wdata = '0;
        in_ren = 1'b0; in_clr_err = 1'b0;
    endtask

    task automatic set_wr(input int k, input logic [4:0] a, input logic [XL-1:0] d);
        in_wen[k] = 1'b1;
        in_waddr[5*k +: 5] = a;
        in_wdata[XL*k +: XL] = d;
    endtask

    task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
        in_ren = 1'b1; in_raddr1 = a1; in_raddr2 = a2;
    endtask

    // Applies the register-file rules to the currently driven inputs.
    task automatic model_edge();
        logic [XL-1:0] nregs [32];
        int cnt;
        int low;
        low = 0;
        for (int a = 0; a < 32; a++) nregs[a] = m_regs[a];
        for (int a = 1; a < 32; a++) begin
            cnt = 0;
            for (int k = 0; k < NW; k++) begin
                if (in_wen[k] && in_waddr[5*k +: 5] == a[4:0]) begin
                    if (cnt == 0) nregs[a] = in_wdata[XL*k +: XL];
                    cnt++;
                end
            end
            if (cnt > 1 && low == 0) low = a;
        end
        if (in_ren) begin
            m_r1 = nregs[in_raddr1];
            m_r2 = nregs[in_raddr2];
        end
        if (low != 0) begin
            if (!m_coll || in_clr_err) m_caddr = low[4:0];
            m_coll = 1'b1;
        end else if (in_clr_err) begin
            m_coll = 1'b0; m_caddr = '0;
        end
        for (int a = 0; a < 32; a++) m_regs[a] = nregs[a];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rdata1"}, out_rdata1, m_r1);
        chk({tag, ".rdata2"}, out_rdata2, m_r2);
        chk({tag, ".coll"}, {31'd0, out_collision}, {31'd0, m_coll});
        chk({tag, ".caddr"}, {27'd0, out_coll_addr}, {27'd0, m_caddr});
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge in_clk);
        #1;
        check_all(tag);
        idle();
    endtask

    initial begin
        in_rst = 1'b0;
        in_raddr1 = '0; in_raddr2 = '0;
        idle();
        model_reset();
        #2;
        chk("rst.rdata1", out_rdata1, '0);
        chk("rst.rdata2", out_rdata2, '0);
        chk("rst.coll", {31'd0, out_collision}, '0);
        chk("rst.caddr", {27'd0, out_coll_addr}, '0);
        @(negedge in_clk);
        in_rst = 1'b1;
        @(posedge in_clk);
        #1;

        for (int i = 1; i < 32; i++) begin
            set_rd(i[4:0], 5'(32 - i));
            step("rd_zero");
        end

        set_wr(0, 5'd5, 32'hDEADBEEF);
        step("wr_x5");
        set_rd(5'd5, 5'd5);
        step("rd_x5");
        chk("rd_x5.value", out_rdata1, 32'hDEADBEEF);

        set_wr(2, 5'd0, 32'h12345678);
        step("wr_x0");
        set_rd(5'd0, 5'd0);
        step("rd_x0");
        chk("rd_x0.value", out_rdata2, '0);
        chk("rd_x0.nocoll", {31'd0, out_collision}, '0);

        set_wr(1, 5'd7, 32'h11);
        set_wr(3, 5'd7, 32'h33);
        step("coll_x7");
        chk("coll_x7.addr", {27'd0, out_coll_addr}, 32'd7);
        set_wr(0, 5'd9, 32'h9A);
        set_wr(2, 5'd9, 32'h9B);
        set_rd(5'd7, 5'd9);
        step("coll_x9");
        chk("coll_x9.keep", {27'd0, out_coll_addr}, 32'd7);
        chk("coll_x7.win", out_rdata1, 32'h11);
        in_clr_err = 1'b1;
        step("clr");
        chk("clr.flag", {31'd0, out_collision}, '0);

        set_wr(3, 5'd12, 32'h1);
        set_wr(1, 5'd12, 32'h2);
        set_wr(0, 5'd20, 32'h3);
        set_wr(2, 5'd20, 32'h4);
        step("coll_two");
        chk("coll_two.low", {27'd0, out_coll_addr}, 32'd12);
        set_wr(0, 5'd15, 32'h5);
        set_wr(1, 5'd15, 32'h6);
        in_clr_err = 1'b1;
        step("clr_vs_coll");
        chk("clr_vs_coll.addr", {27'd0, out_coll_addr}, 32'd15);
        in_clr_err = 1'b1;
        step("clr2");

        set_wr(0, 5'd10, 32'hA5A5A5A5);
        set_rd(5'd10, 5'd3);
        step("bypass");
        chk("bypass.value", out_rdata1, 32'hA5A5A5A5);
        set_rd(5'd3, 5'd10);
        step("bypass_next");
        chk("bypass_next.value", out_rdata2, 32'hA5A5A5A5);

        for (int k = 0; k < NW; k++) set_wr(k, 5'(k + 1), 32'(k + 1));
        step("wr_four");
        for (int i = 1; i <= 4; i++) begin
            set_rd(i[4:0], 5'(5 - i));
            step("rd_four");
        end
        for (int i = 0; i < 4; i++) begin
            in_ren = 1'b0;
            in_raddr1 = 5'($urandom_range(0, 31));
            in_raddr2 = 5'($urandom_range(0, 31));
            step("ren_low");
        end
        chk("ren_low.hold", out_rdata1, 32'd4);

        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NW; k++) begin
                if ($urandom_range(0, 1) == 1)
                    set_wr(k, 5'($urandom_range(0, 7)), $urandom);
            end
            if ($urandom_range(0, 3) != 0)
                set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            in_clr_err = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < NW; k++) set_wr(k, 5'(n + 1), 32'hF0 + 32'(k));
            set_rd(5'(n + 1), 5'd2);
            step("burst");
        end
        for (int k = 0; k < NW; k++) set_wr(k, 5'(k + 20), $urandom);
        set_rd(5'd21, 5'd22);
        #2;
        in_rst = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        @(posedge in_clk);
        #1;
        check_all("mid_rst_hold");
        @(negedge in_clk);
        idle();
        in_rst = 1'b1;
        for (int i = 1; i < 32; i += 2) begin
            set_rd(i[4:0], 5'(i + 1));
            step("post_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
